// File: rtl/mem_pkg.sv
// Shared definitions for the ram_bank data memory: read-during-write mode
// codes, clear-engine state encoding and a constant clog2 helper.
// No ports; imported by ram_bank and ram_clear_fsm.
package mem_pkg;

  localparam int RDW_WRITE_FIRST = 0;  // write echo returns the merged new word
  localparam int RDW_READ_FIRST  = 1;  // write echo returns the old word

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_t;

  // Address width for a given word count; never below 1 bit.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/ram_clear_fsm.sv
// Clear engine for ram_bank: walks ptr 0..DEPTH-1 writing zero, one word per
// cycle, either after reset release (CLEAR_ON_RESET) or on clr_req in IDLE.
// Ports: clk, rst (async, active-high), clr_req in; busy, clr_done (1-cycle
// pulse after the last word), clr_we / clr_addr (write-port mux select/addr) out.
module ram_clear_fsm
  import mem_pkg::*;
#(
  parameter int DEPTH          = 2048,
  parameter int AW             = clog2(DEPTH),
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_req,
  output logic          busy,
  output logic          clr_done,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  clr_state_t    state, state_nxt;
  logic [AW-1:0] ptr, ptr_nxt;
  logic          done_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
      ptr      <= '0;
      clr_done <= 1'b0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      clr_done <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = '0;
    done_nxt  = 1'b0;
    busy      = 1'b0;
    clr_we    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (clr_req) state_nxt = ST_CLEAR;
      end
      ST_CLEAR: begin
        busy   = 1'b1;
        clr_we = 1'b1;
        // The last word is written this cycle; the following cycle is IDLE
        // with the done pulse, so requests can be accepted right away.
        if (ptr == LAST) begin
          state_nxt = ST_IDLE;
          done_nxt  = 1'b1;
        end else begin
          ptr_nxt = ptr + AW'(1);
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign clr_addr = ptr;

endmodule

// File: rtl/ram_bank.sv
// Single-port synchronous data memory with byte enables, selectable
// read-during-write echo, 1- or 2-cycle read latency, range check and clear engine.
// Ports: clk, rst, req/wen/be/addr/dataIn request in; data/rvalid/addr_err
// response out; busy, clr_req in, clr_done out for the clear engine.
module ram_bank
  import mem_pkg::*;
#(
  parameter int DW             = 32,
  parameter int DEPTH          = 2048,
  parameter int AW             = clog2(DEPTH),
  parameter int READ_LAT       = 1,
  parameter int RDW_MODE       = RDW_WRITE_FIRST,
  parameter int CLEAR_ON_RESET = 1,
  parameter     INIT_FILE      = ""
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req,
  input  logic            wen,
  input  logic [DW/8-1:0] be,
  input  logic [AW-1:0]   addr,
  input  logic [DW-1:0]   dataIn,
  output logic [DW-1:0]   data,
  output logic            rvalid,
  output logic            addr_err,
  output logic            busy,
  input  logic            clr_req,
  output logic            clr_done
);

  localparam int          NB      = DW / 8;
  localparam logic [AW:0] DEPTH_L = (AW + 1)'(DEPTH);

  logic [DW-1:0] mem [0:DEPTH-1];

  logic          clr_we;
  logic [AW-1:0] clr_addr;
  logic          accept, in_range;
  logic          we;
  logic [AW-1:0] wa, rd_idx;
  logic [DW-1:0] wd;
  logic [NB-1:0] wbe;

  ram_clear_fsm #(
    .DEPTH          (DEPTH),
    .AW             (AW),
    .CLEAR_ON_RESET (CLEAR_ON_RESET)
  ) u_clr (
    .clk      (clk),
    .rst      (rst),
    .clr_req  (clr_req),
    .busy     (busy),
    .clr_done (clr_done),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  assign accept   = req & ~busy;
  assign in_range = ({1'b0, addr} < DEPTH_L);
  // Keep the array read in bounds; out-of-range results are forced to zero later.
  assign rd_idx   = in_range ? addr : '0;

  // Single write port: the clear engine owns it while busy, so it never
  // collides with an accepted request.
  always_comb begin
    we  = 1'b0;
    wa  = addr;
    wd  = dataIn;
    wbe = be;
    if (clr_we) begin
      we  = 1'b1;
      wa  = clr_addr;
      wd  = '0;
      wbe = '1;
    end else if (accept && wen && in_range) begin
      we = 1'b1;
    end
  end

  // Array: no reset, synchronous read that returns the pre-write word.
  logic [DW-1:0] rd_q;
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < NB; i++) begin
        if (wbe[i]) mem[wa][8*i +: 8] <= wd[8*i +: 8];
      end
    end
    if (accept) rd_q <= mem[rd_idx];
  end

  // Stage 1 request context; the write-first merge is rebuilt from the old
  // word after the array so the array itself stays a plain read-first RAM.
  logic          v1, oor1, wen1;
  logic [NB-1:0] be1;
  logic [DW-1:0] din1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1   <= 1'b0;
      oor1 <= 1'b0;
      wen1 <= 1'b0;
      be1  <= '0;
      din1 <= '0;
    end else begin
      v1 <= accept;
      if (accept) begin
        oor1 <= ~in_range;
        wen1 <= wen;
        be1  <= be;
        din1 <= dataIn;
      end
    end
  end

  logic [DW-1:0] mask1, word1, out1;
  always_comb begin
    mask1 = '0;
    for (int i = 0; i < NB; i++) mask1[8*i +: 8] = {8{be1[i]}};
    if (oor1)
      word1 = '0;
    else if (wen1 && (RDW_MODE != RDW_READ_FIRST))
      word1 = (rd_q & ~mask1) | (din1 & mask1);
    else
      word1 = rd_q;
    out1 = v1 ? word1 : '0;
  end

  generate
    if (READ_LAT == 2) begin : g_lat2
      logic          v2, err2;
      logic [DW-1:0] data2;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          v2    <= 1'b0;
          err2  <= 1'b0;
          data2 <= '0;
        end else begin
          v2    <= v1;
          err2  <= v1 & oor1;
          data2 <= out1;
        end
      end
      assign rvalid   = v2;
      assign addr_err = err2;
      assign data     = data2;
    end else begin : g_lat1
      assign rvalid   = v1;
      assign addr_err = v1 & oor1;
      assign data     = out1;
    end
  endgenerate

endmodule

// File: tb/tb_ram_bank.sv
module tb_ram_bank;

  localparam int N = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        wen = 1'b0;
  logic        clr_req = 1'b0;
  logic [3:0]  be = 4'h0;
  logic [10:0] addr = '0;
  logic [31:0] din = '0;

  logic [31:0] dout  [N];
  logic        rv    [N];
  logic        aerr  [N];
  logic        bsy   [N];
  logic        cdone [N];

  // d0: 16 words, latency 1, write-first
  ram_bank #(.DW(32), .DEPTH(16), .READ_LAT(1), .RDW_MODE(0), .CLEAR_ON_RESET(1)) u_d0 (
    .clk(clk), .rst(rst), .req(req), .wen(wen), .be(be), .addr(addr[3:0]), .dataIn(din),
    .data(dout[0]), .rvalid(rv[0]), .addr_err(aerr[0]), .busy(bsy[0]),
    .clr_req(clr_req), .clr_done(cdone[0]));

  // d1: 16 words, latency 2, read-first
  ram_bank #(.DW(32), .DEPTH(16), .READ_LAT(2), .RDW_MODE(1), .CLEAR_ON_RESET(1)) u_d1 (
    .clk(clk), .rst(rst), .req(req), .wen(wen), .be(be), .addr(addr[3:0]), .dataIn(din),
    .data(dout[1]), .rvalid(rv[1]), .addr_err(aerr[1]), .busy(bsy[1]),
    .clr_req(clr_req), .clr_done(cdone[1]));

  // d2: 2000 words (non power of two), latency 1, write-first
  ram_bank #(.DW(32), .DEPTH(2000), .READ_LAT(1), .RDW_MODE(0), .CLEAR_ON_RESET(1)) u_d2 (
    .clk(clk), .rst(rst), .req(req), .wen(wen), .be(be), .addr(addr), .dataIn(din),
    .data(dout[2]), .rvalid(rv[2]), .addr_err(aerr[2]), .busy(bsy[2]),
    .clr_req(clr_req), .clr_done(cdone[2]));

  initial forever #5 clk = ~clk;

  function automatic int dep(input int k);
    return (k == 2) ? 2000 : 16;
  endfunction
  function automatic int lat(input int k);
    return (k == 1) ? 2 : 1;
  endfunction
  function automatic int rdw(input int k);
    return (k == 1) ? 1 : 0;
  endfunction

  // Reference model: word arrays, the edge index of each DUT's last clear
  // write, and the expected response produced by the request at each edge.
  logic [31:0] mm [N][2048];
  int          clr_last [N];
  logic        hv [N][4];
  logic        he [N][4];
  logic [31:0] hd [N][4];
  int          n;
  int          tests;
  int          fails;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      if (fails <= 40) $display("FAIL %s cyc=%0d got=%h want=%h", tag, n, got, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d,
                                        input logic [3:0] b);
    logic [31:0] m;
    m = o;
    for (int i = 0; i < 4; i++) if (b[i]) m[8*i +: 8] = d[8*i +: 8];
    return m;
  endfunction

  task automatic zero_model(input int k);
    for (int i = 0; i < 2048; i++) mm[k][i] = '0;
  endtask

  task automatic model_edge(input bit r, input bit was_rst, input bit rq, input bit wn,
                            input logic [3:0] b, input logic [10:0] a,
                            input logic [31:0] d, input bit cr);
    logic [10:0] ak;
    logic [31:0] old, mrg;
    bit          oor;
    for (int k = 0; k < N; k++) begin
      if (r) begin
        clr_last[k] = 32'h7fffffff;
        for (int j = 0; j < 4; j++) begin
          hv[k][j] = 1'b0; he[k][j] = 1'b0; hd[k][j] = '0;
        end
      end else begin
        if (was_rst) begin
          clr_last[k] = n + dep(k) - 1;
          zero_model(k);
        end
        hv[k][n%4] = 1'b0; he[k][n%4] = 1'b0; hd[k][n%4] = '0;
        if (n > clr_last[k]) begin
          if (rq) begin
            ak  = (k == 2) ? a : {7'b0, a[3:0]};
            oor = (int'(ak) >= dep(k));
            old = oor ? 32'h0 : mm[k][ak];
            mrg = merge(old, d, b);
            if (wn && !oor) mm[k][ak] = mrg;
            hv[k][n%4] = 1'b1;
            he[k][n%4] = oor;
            hd[k][n%4] = oor ? 32'h0 : ((wn && rdw(k) == 0) ? mrg : old);
          end
          if (cr) begin
            clr_last[k] = n + dep(k);
            zero_model(k);
          end
        end
      end
    end
  endtask

  task automatic check_out();
    int idx;
    for (int k = 0; k < N; k++) begin
      idx = (n + 5 - lat(k)) % 4;
      chk($sformatf("d%0d.rvalid", k), 32'(rv[k]), 32'(hv[k][idx]));
      chk($sformatf("d%0d.addr_err", k), 32'(aerr[k]), 32'(hv[k][idx] & he[k][idx]));
      if (hv[k][idx]) chk($sformatf("d%0d.data", k), dout[k], hd[k][idx]);
      chk($sformatf("d%0d.busy", k), 32'(bsy[k]), 32'(n < clr_last[k]));
      chk($sformatf("d%0d.clr_done", k), 32'(cdone[k]), 32'(n == clr_last[k]));
      if (rst) chk($sformatf("d%0d.rst_data", k), dout[k], 32'h0);
    end
  endtask

  // One clock: drive inputs (we are at a falling edge), advance the model for
  // the coming rising edge, then sample outputs at the next falling edge.
  task automatic tick(input bit r, input bit rq, input bit wn, input logic [3:0] b,
                      input logic [10:0] a, input logic [31:0] d, input bit cr);
    bit was_rst;
    was_rst = rst;
    rst = r; req = rq; wen = wn; be = b; addr = a; din = d; clr_req = cr;
    if (r && !was_rst) begin
      #1;
      for (int k = 0; k < N; k++) begin
        chk($sformatf("d%0d.rst_now_rvalid", k), 32'(rv[k]), 32'h0);
        chk($sformatf("d%0d.rst_now_data", k), dout[k], 32'h0);
        chk($sformatf("d%0d.rst_now_err", k), 32'(aerr[k]), 32'h0);
        chk($sformatf("d%0d.rst_now_done", k), 32'(cdone[k]), 32'h0);
        chk($sformatf("d%0d.rst_now_busy", k), 32'(bsy[k]), 32'h1);
      end
    end
    model_edge(r, was_rst, rq, wn, b, a, d, cr);
    @(posedge clk);
    @(negedge clk);
    check_out();
    n++;
  endtask

  function automatic logic [10:0] pick_addr();
    int s;
    s = $urandom_range(0, 9);
    if (s < 6)      return 11'($urandom_range(0, 15));
    else if (s < 8) return 11'($urandom_range(1990, 2047));
    else            return 11'($urandom_range(0, 2047));
  endfunction

  task automatic rnd_tick();
    tick(1'b0, ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 4'($urandom),
         pick_addr(), $urandom, 1'b0);
  endtask

  task automatic wr(input logic [10:0] a, input logic [31:0] d, input logic [3:0] b);
    tick(1'b0, 1'b1, 1'b1, b, a, d, 1'b0);
  endtask

  task automatic rd(input logic [10:0] a);
    tick(1'b0, 1'b1, 1'b0, 4'h0, a, 32'h0, 1'b0);
  endtask

  task automatic idle(input int c);
    for (int i = 0; i < c; i++) tick(1'b0, 1'b0, 1'b0, 4'h0, 11'h0, 32'h0, 1'b0);
  endtask

  initial begin
    n = 0; tests = 0; fails = 0;
    for (int k = 0; k < N; k++) begin
      clr_last[k] = 32'h7fffffff;
      zero_model(k);
      for (int j = 0; j < 4; j++) begin
        hv[k][j] = 1'b0; he[k][j] = 1'b0; hd[k][j] = '0;
      end
    end

    // Reset, then clear-on-reset; requests during the clear must be ignored.
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 1'b0, 4'h0, 11'h0, 32'h0, 1'b0);
    for (int i = 0; i < 20; i++) rnd_tick();
    for (int i = 0; i < 16; i++) rd(11'(i));

    // Byte-lane merge and back-to-back latency.
    wr(11'd5, 32'hAABBCCDD, 4'hF);
    wr(11'd5, 32'h11223344, 4'h5);
    rd(11'd5);
    idle(2);

    // Read-during-write echo (d0 write-first, d1 read-first).
    wr(11'd3, 32'h12345678, 4'hF);
    idle(1);
    wr(11'd3, 32'hFFFFFFFF, 4'hF);
    rd(11'd3);
    wr(11'd9, 32'hCAFEF00D, 4'h0);
    rd(11'd9);
    idle(2);

    // Let the 2000-word bank finish its clear under random traffic.
    for (int i = 0; i < 2000; i++) rnd_tick();

    // Range check on the 2000-word bank.
    wr(11'd2047, 32'hDEADBEEF, 4'hF);
    rd(11'd0);
    rd(11'd1999);
    wr(11'd1999, 32'h0BADF00D, 4'hF);
    rd(11'd1999);
    rd(11'd2000);
    idle(2);
    for (int i = 0; i < 300; i++) rnd_tick();

    // clr_req with a read in the same cycle, then reads while busy and after.
    tick(1'b0, 1'b1, 1'b0, 4'h0, 11'd7, 32'h0, 1'b1);
    for (int i = 0; i < 40; i++) rd(11'(i % 16));
    for (int i = 0; i < 1980; i++) rd(pick_addr());
    for (int i = 0; i < 16; i++) rd(11'(i));
    for (int i = 1990; i < 2000; i++) rd(11'(i));
    for (int i = 0; i < 50; i++) rnd_tick();

    // Reset at clear cycle 7: the run restarts from address 0.
    tick(1'b0, 1'b0, 1'b0, 4'h0, 11'h0, 32'h0, 1'b1);
    idle(7);
    tick(1'b1, 1'b1, 1'b0, 4'h0, 11'h0, 32'h0, 1'b0);
    tick(1'b1, 1'b0, 1'b0, 4'h0, 11'h0, 32'h0, 1'b0);
    for (int i = 0; i < 2030; i++) rnd_tick();
    for (int i = 0; i < 16; i++) rd(11'(i));
    idle(3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
